// File: rtl/dmem_port_arbiter_if.sv
// Shared D-MEM bus bundle: pipeline port P, debug port D and the memory-side signals.
// The arbiter takes the slave view; requesters and the memory array take the master view.
interface dmem_port_arbiter_if #(
  parameter int unsigned DBITS = 32
);
  logic             p_req;
  logic             p_we;
  logic [DBITS-1:0] p_addr;
  logic [DBITS-1:0] p_wdata;
  logic             p_gnt;
  logic             p_stall;
  logic             p_rvalid;
  logic [DBITS-1:0] p_rdata;

  logic             d_req;
  logic             d_we;
  logic [DBITS-1:0] d_addr;
  logic [DBITS-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [DBITS-1:0] d_rdata;

  logic             mem_en;
  logic             mem_we;
  logic [DBITS-1:0] mem_addr;
  logic [DBITS-1:0] mem_wdata;
  logic [DBITS-1:0] mem_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_gnt, p_stall, p_rvalid, p_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_gnt, p_stall, p_rvalid, p_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Fixed-priority D-MEM arbiter (pipeline over debug) with a starvation guard that
// forces a debug grant after MAX_WAIT denials, plus 1-cycle read-return routing.
module dmem_port_arbiter #(
  parameter int unsigned DBITS    = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus,
  output logic [3:0]           wait_cnt_o
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       pend_p_q, pend_p_d;
  logic       pend_d_q, pend_d_d;
  logic       force_d;
  logic       p_gnt;
  logic       d_gnt;

  always_comb begin
    force_d = bus.d_req && (wait_cnt_q == MAX_W);
    p_gnt   = bus.p_req && !force_d;
    d_gnt   = bus.d_req && !p_gnt;

    bus.p_gnt   = p_gnt;
    bus.d_gnt   = d_gnt;
    bus.p_stall = bus.p_req && !p_gnt;

    bus.mem_en    = p_gnt || d_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (p_gnt) begin
      bus.mem_we    = bus.p_we;
      bus.mem_addr  = bus.p_addr;
      bus.mem_wdata = bus.p_wdata;
    end else if (d_gnt) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end

    // Counter only survives while D keeps requesting and keeps losing.
    wait_cnt_d = '0;
    if (bus.d_req && !d_gnt)
      wait_cnt_d = (wait_cnt_q == MAX_W) ? wait_cnt_q : wait_cnt_q + 4'd1;

    pend_p_d = p_gnt && !bus.p_we;
    pend_d_d = d_gnt && !bus.d_we;

    bus.p_rvalid = pend_p_q;
    bus.d_rvalid = pend_d_q;
    bus.p_rdata  = pend_p_q ? bus.mem_rdata : '0;
    bus.d_rdata  = pend_d_q ? bus.mem_rdata : '0;
    wait_cnt_o   = wait_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      pend_p_q   <= 1'b0;
      pend_d_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      pend_p_q   <= pend_p_d;
      pend_d_q   <= pend_d_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Vector-table bench for dmem_port_arbiter with a behavioural D-MEM and a read-return scoreboard.
module tb_dmem_port_arbiter;

  localparam int unsigned DBITS = 32;

  logic       clk;
  logic       reset;
  logic [3:0] wait_cnt_o;
  int         cyc;
  int         n_checks;
  int         n_err;
  bit         mon_en;

  dmem_port_arbiter_if #(.DBITS(DBITS)) bus ();

  dmem_port_arbiter #(.DBITS(DBITS), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .wait_cnt_o (wait_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: write commits at the grant edge, read data one cycle later.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  typedef struct {
    bit          rst;
    bit          p_req;
    bit          p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    bit          d_req;
    bit          d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    bit          e_p_gnt;
    bit          e_d_gnt;
    logic [3:0]  e_wait;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    bit          port_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(bit rst, bit pr, bit pw, logic [31:0] pa, logic [31:0] pd,
                              bit dr, bit dw, logic [31:0] da, logic [31:0] dd,
                              bit egp, bit egd, logic [3:0] ew, logic [31:0] er);
    vec_t v;
    v.rst = rst; v.p_req = pr; v.p_we = pw; v.p_addr = pa; v.p_wdata = pd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.e_p_gnt = egp; v.e_d_gnt = egd; v.e_wait = ew; v.e_rdata = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Read-return monitor: every rvalid must match the oldest expected read, in its cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.p_rvalid || bus.d_rvalid) begin
        chk("rvalid_both", {31'd0, bus.p_rvalid & bus.d_rvalid}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("rvalid_port", {31'd0, bus.d_rvalid}, {31'd0, e.port_d});
          chk("rdata", e.port_d ? bus.d_rdata : bus.p_rdata, e.data);
        end
      end
      if (!bus.p_rvalid) chk("p_rdata_idle", bus.p_rdata, 32'd0);
      if (!bus.d_rvalid) chk("d_rdata_idle", bus.d_rdata, 32'd0);
    end
  end

  initial begin
    localparam logic [31:0] Z = 32'd0;
    cyc = 0; n_checks = 0; n_err = 0; mon_en = 0;
    for (int unsigned i = 0; i < 256; i++) mem[i] = '0;
    mem[32'h40 >> 2] = 32'hDEADBEEF;
    mem[32'h44 >> 2] = 32'h0BADF00D;

    //         rst pr pw p_addr   p_wdata         dr dw d_addr   d_wdata         gp gd w  rdata
    vecs.push_back(mk(1, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,0, Z));
    // single P read
    vecs.push_back(mk(0, 1,0,32'h40, Z,            0,0,Z,      Z,            1,0,0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,0, Z));
    // continuous contention, MAX_WAIT=4
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            1,0,0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            1,0,1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            1,0,2, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            1,0,3, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            0,1,4, 32'h0BADF00D));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            1,0,0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            1,0,1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            1,0,2, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,0,32'h44, Z,            1,0,3, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,4, Z));
    // D write with P idle, then P reads it back
    vecs.push_back(mk(0, 0,0,Z,      Z,            1,1,32'h80, 32'h12345678, 0,1,0, Z));
    vecs.push_back(mk(0, 1,0,32'h80, Z,            0,0,Z,      Z,            1,0,0, 32'h12345678));
    vecs.push_back(mk(0, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,0, Z));
    // P write at N, D read of same address at N+1
    vecs.push_back(mk(0, 1,1,32'h90, 32'hA5A5A5A5, 0,0,Z,      Z,            1,0,0, Z));
    vecs.push_back(mk(0, 0,0,Z,      Z,            1,0,32'h90, Z,            0,1,0, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,0, Z));
    // D starved 3 cycles, drops for one, re-asserts: 4 more denials then forced grant
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        1,0,32'h44, Z,            1,0,0, Z));
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        1,0,32'h44, Z,            1,0,1, Z));
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        1,0,32'h44, Z,            1,0,2, Z));
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        0,0,Z,      Z,            1,0,3, Z));
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        1,0,32'h44, Z,            1,0,0, Z));
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        1,0,32'h44, Z,            1,0,1, Z));
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        1,0,32'h44, Z,            1,0,2, Z));
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        1,0,32'h44, Z,            1,0,3, Z));
    vecs.push_back(mk(0, 1,1,32'hA0, 32'h1,        1,0,32'h44, Z,            0,1,4, 32'h0BADF00D));
    vecs.push_back(mk(0, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,0, Z));
    // partial starvation, then a P read granted in a reset cycle
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,1,32'hB0, 32'h5,        1,0,0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            1,1,32'hB0, 32'h5,        1,0,1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1,0,32'h40, Z,            1,1,32'hB0, 32'h5,        1,0,2, Z));
    vecs.push_back(mk(0, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,0, Z));
    vecs.push_back(mk(0, 1,0,32'h40, Z,            0,0,Z,      Z,            1,0,0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,0, Z));
    vecs.push_back(mk(0, 0,0,Z,      Z,            0,0,Z,      Z,            0,0,0, Z));

    reset = 1'b1;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    mon_en = 1;

    foreach (vecs[i]) begin
      vec_t v;
      logic [31:0] e_addr;
      v = vecs[i];
      @(negedge clk);
      reset = v.rst;
      bus.p_req = v.p_req; bus.p_we = v.p_we; bus.p_addr = v.p_addr; bus.p_wdata = v.p_wdata;
      bus.d_req = v.d_req; bus.d_we = v.d_we; bus.d_addr = v.d_addr; bus.d_wdata = v.d_wdata;
      #1;
      e_addr = v.e_p_gnt ? v.p_addr : (v.e_d_gnt ? v.d_addr : 32'd0);
      chk($sformatf("p_gnt[%0d]", i),   {31'd0, bus.p_gnt},   {31'd0, v.e_p_gnt});
      chk($sformatf("d_gnt[%0d]", i),   {31'd0, bus.d_gnt},   {31'd0, v.e_d_gnt});
      chk($sformatf("p_stall[%0d]", i), {31'd0, bus.p_stall}, {31'd0, v.p_req & ~v.e_p_gnt});
      chk($sformatf("mem_en[%0d]", i),  {31'd0, bus.mem_en},  {31'd0, v.e_p_gnt | v.e_d_gnt});
      chk($sformatf("mem_addr[%0d]", i), bus.mem_addr, e_addr);
      chk($sformatf("wait_cnt[%0d]", i), {28'd0, wait_cnt_o}, {28'd0, v.e_wait});
      if (v.e_p_gnt) chk($sformatf("mem_we[%0d]", i), {31'd0, bus.mem_we}, {31'd0, v.p_we});
      if (v.e_d_gnt) chk($sformatf("mem_we[%0d]", i), {31'd0, bus.mem_we}, {31'd0, v.d_we});
      if (!v.rst && v.e_p_gnt && !v.p_we) sb.push_back('{1'b0, v.e_rdata, cyc + 1});
      if (!v.rst && v.e_d_gnt && !v.d_we) sb.push_back('{1'b1, v.e_rdata, cyc + 1});
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter for the single data-memory port. It shares the D-MEM between the pipeline MEM stage (port P) and the debug/loader port (port D). Port P has fixed priority, with a starvation guard that forces a grant to port D after a bounded wait. The block sits between the MEM stage, the debug unit and the synchronous D-MEM array, which has a 1-cycle read latency. It also routes read data back to whichever port issued the read.

## Interface
Parameters:
- DBITS, 32, data and address width
- MAX_WAIT, 4, maximum consecutive cycles port D may be denied while requesting (legal range 1..15)

Ports:
- Clock is `clk`; reset is `reset`, synchronous, active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- p_req  in  1  pipeline request valid
- p_we  in  1  pipeline request is a write
- p_addr  in  DBITS  pipeline byte address
- p_wdata  in  DBITS  pipeline write data
- p_gnt  out  1  pipeline request accepted this cycle (combinational)
- p_stall  out  1  p_req & ~p_gnt; the MEM stage holds its latch while this is high
- p_rvalid  out  1  read data for port P is valid this cycle
- p_rdata  out  DBITS  read data for port P
- d_req, d_we, d_addr, d_wdata  in  1/1/DBITS/DBITS  debug-port request, same meaning as the P-port signals
- d_gnt  out  1  debug request accepted this cycle (combinational)
- d_rvalid  out  1  read data for port D is valid this cycle
- d_rdata  out  DBITS  read data for port D
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  DBITS  byte address to memory (memory indexes by word)
- mem_wdata  out  DBITS  memory write data
- mem_rdata  in  DBITS  memory read data, valid 1 cycle after a read enable
- wait_cnt_o  out  4  current starvation count, for debug visibility

## Operation
Grant decision is combinational each cycle and is made in this order:
- If `d_req` is high and `wait_cnt == MAX_WAIT`, port D is granted (forced grant).
- Otherwise, if `p_req` is high, port P is granted.
- Otherwise, if `d_req` is high, port D is granted.
- Otherwise there is no grant, and `mem_en` = 0.

At most one of `p_gnt`/`d_gnt` is high in any cycle. The `mem_*` outputs are muxed from the granted port; when nothing is granted they are all 0.

Starvation counter (`wait_cnt`, 4 bits, registered):
- It increments when `d_req & ~d_gnt`, saturating at MAX_WAIT.
- It clears to 0 when `d_gnt` is high or `d_req` is low.

Read-return tracking uses registered flags `pend_p` and `pend_d`:
- Next cycle, `pend_p` = `p_gnt & ~p_we` and `pend_d` = `d_gnt & ~d_we`.
- `p_rvalid` = `pend_p` and `d_rvalid` = `pend_d`.
- `p_rdata` = `pend_p ? mem_rdata : 0`, and `d_rdata` likewise gated by `pend_d`.

Write behaviour:
- Writes produce no rvalid.
- The write commits at the clock edge in the grant cycle.

Requesters must hold `req`, `we`, `addr` and `wdata` stable until they see their grant. The arbiter does not buffer ungranted requests.

## Timing
- Reset values: `wait_cnt` = 0, `pend_p` = `pend_d` = 0, and therefore every rvalid/rdata output is 0.
- Grant outputs and `mem_*` outputs depend only on the current inputs and `wait_cnt`. In the reset cycle they still follow the inputs, but the registers hold their reset values.
- Read latency is 1 cycle: grant at cycle N, rvalid and rdata at cycle N+1.
- Back-to-back reads from the same port are supported, giving one result per cycle.
- A read granted in the cycle that reset is asserted produces no rvalid, because `pend` is cleared.
- Port D's worst-case wait is MAX_WAIT cycles. While the forced grant is active, `p_stall` = 1 for exactly that one cycle, and then `wait_cnt` = 0.
- Simultaneous requests when `wait_cnt < MAX_WAIT`: P wins and D's counter advances.
- If `d_req` drops while D is starved, the counter clears; no forced grant is remembered.
- Same-address hazard when P writes at N and D reads at N+1: D sees the new data, because the write commits at the N edge.

## Test plan
- Reset, then a single P read at address 0x40 whose stored word is 0xDEADBEEF → `p_gnt`=1 at cycle 1; `p_rvalid`=1 and `p_rdata`=0xDEADBEEF at cycle 2; `d_rvalid` stays 0.
- P and D both request continuously with MAX_WAIT=4 → P is granted in cycles 1-4, D in cycle 5 (`p_stall`=1 in that cycle), P again in cycles 6-9. `wait_cnt_o` follows 1,2,3,4,0.
- D writes 0x12345678 to 0x80 with P idle → `d_gnt`=1 in the same cycle. A subsequent P read of 0x80 returns 0x12345678 one cycle after its grant.
- P writes 0xA5A5A5A5 at cycle N; D reads the same address at N+1 → `d_rvalid`=1 at N+2 with `d_rdata`=0xA5A5A5A5.
- D is starved for 3 cycles, drops `d_req` for 1 cycle, then re-asserts → `wait_cnt_o` = 0 after the drop, and D is next granted after 4 further denials.
- P read granted in cycle N with `reset`=1 in cycle N → `p_rvalid`=0 at N+1. All counters read 0, and the next normal request behaves exactly as after power-up.
